neuromorphic_x1_wb_master: RTL and testbench

- Wishbone classic single-transfer initiator that drives the Neuromorphic_X1 crossbar's Wishbone slave port from a simple valid/ready command stream.
- Issues one 32-bit read or write per command and waits for ack, with a timeout. Returns read data or an error on a response stream.
- Sits between the on-chip sequencer (or a test controller) and the macro, in the wb_clk_i domain.

---
 rtl/neuromorphic_x1_pkg.sv | 16 +
 rtl/neuromorphic_x1_wb_timer.sv | 34 +++
 rtl/neuromorphic_x1_wb_master.sv | 160 ++++++++++++++++
 tb/tb_neuromorphic_x1_wb_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuromorphic_x1_pkg.sv
// Shared types and constants for the Neuromorphic_X1 Wishbone initiator.
package neuromorphic_x1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  localparam logic [3:0]  WB_SEL_FULL = 4'hF;
  localparam int          WB_ADR_W    = 32;
  localparam int          WB_DAT_W    = 32;
  localparam logic [31:0] RSP_ERR_DAT = 32'h0;
  localparam int          CNT_W       = 16;

endpackage

// File: rtl/neuromorphic_x1_wb_timer.sv
// Loadable up/down counter with a terminal-count compare.
// Serves as the ack timeout timer and as the post-response idle gap.
module neuromorphic_x1_wb_timer
  import neuromorphic_x1_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/neuromorphic_x1_wb_master.sv
// Wishbone classic single-transfer initiator for the Neuromorphic_X1 crossbar.
// One command in flight; ack timeout reported as an error response.
module neuromorphic_x1_wb_master
  import neuromorphic_x1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int IDLE_GAP       = 2,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [WB_ADR_W-1:0]  cmd_adr,
  input  logic [WB_DAT_W-1:0]  cmd_dat,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_we,
  output logic [WB_DAT_W-1:0]  rsp_dat,
  output logic                 rsp_err,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [WB_ADR_W-1:0]  wbm_adr_o,
  output logic [WB_DAT_W-1:0]  wbm_dat_o,
  input  logic [WB_DAT_W-1:0]  wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(IDLE_GAP);

  state_t                state, state_n;
  logic                  cyc_n, we_n;
  logic [WB_ADR_W-1:0]   adr_n;
  logic [WB_DAT_W-1:0]   dat_n;
  logic                  rv_n, rwe_n, rerr_n;
  logic [WB_DAT_W-1:0]   rdat_n;
  logic [ERR_CNT_W-1:0]  ecnt_n;
  logic                  tmr_clr, tmr_inc, tmr_last;
  logic                  gap_ld, gap_dec, gap_zero;

  assign cmd_ready = (state == IDLE) && gap_zero;
  assign busy      = (state != IDLE);
  assign wbm_sel_o = WB_SEL_FULL;
  assign wbm_stb_o = wbm_cyc_o;

  always_comb begin
    state_n = state;
    cyc_n   = wbm_cyc_o;
    we_n    = wbm_we_o;
    adr_n   = wbm_adr_o;
    dat_n   = wbm_dat_o;
    rv_n    = rsp_valid;
    rwe_n   = rsp_we;
    rerr_n  = rsp_err;
    rdat_n  = rsp_dat;
    ecnt_n  = err_cnt;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    gap_ld  = 1'b0;
    gap_dec = 1'b0;
    unique case (state)
      IDLE: begin
        gap_dec = !gap_zero;
        if (cmd_valid && gap_zero) begin
          we_n    = cmd_we;
          adr_n   = cmd_adr;
          dat_n   = cmd_dat;
          cyc_n   = 1'b1;
          tmr_clr = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // ack on the terminal timeout cycle still completes normally
        if (wbm_ack_i) begin
          cyc_n   = 1'b0;
          rv_n    = 1'b1;
          rwe_n   = wbm_we_o;
          rerr_n  = 1'b0;
          rdat_n  = wbm_we_o ? '0 : wbm_dat_i;
          state_n = RESP;
        end else if (tmr_last) begin
          cyc_n   = 1'b0;
          rv_n    = 1'b1;
          rwe_n   = wbm_we_o;
          rerr_n  = 1'b1;
          rdat_n  = RSP_ERR_DAT;
          ecnt_n  = (&err_cnt) ? err_cnt
                               : err_cnt + ERR_CNT_W'(1);
          state_n = RESP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_n    = 1'b0;
          gap_ld  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      wbm_cyc_o <= cyc_n;
      wbm_we_o  <= we_n;
      wbm_adr_o <= adr_n;
      wbm_dat_o <= dat_n;
      rsp_valid <= rv_n;
      rsp_we    <= rwe_n;
      rsp_err   <= rerr_n;
      rsp_dat   <= rdat_n;
      err_cnt   <= ecnt_n;
    end
  end

  neuromorphic_x1_wb_timer #(.W(CNT_W)) u_tmr (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tmr_clr),
    .load_val ('0),
    .inc      (tmr_inc),
    .dec      (1'b0),
    .tc_val   (TO_LAST),
    .tc       (tmr_last)
  );

  neuromorphic_x1_wb_timer #(.W(CNT_W)) u_gap (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (gap_ld),
    .load_val (GAP_LD),
    .inc      (1'b0),
    .dec      (gap_dec),
    .tc_val   ('0),
    .tc       (gap_zero)
  );

endmodule

// File: tb/tb_neuromorphic_x1_wb_master.sv
// Scoreboard bench for neuromorphic_x1_wb_master with a simple ack-delay slave.
module tb_neuromorphic_x1_wb_master;

  localparam int TO  = 8;
  localparam int GAP = 2;
  localparam int ECW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_we = 1'b0;
  logic [31:0]    cmd_adr = '0;
  logic [31:0]    cmd_dat = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_we;
  logic [31:0]    rsp_dat;
  logic           rsp_err;
  logic           wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]     wbm_sel_o;
  logic [31:0]    wbm_adr_o, wbm_dat_o;
  logic [31:0]    rdat = '0;
  logic           ack;
  logic           busy;
  logic [ECW-1:0] err_cnt;

  typedef struct {
    logic        we;
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int ack_at = 0;
  logic spur = 1'b0;
  int stb_n = 0;
  int run = 0;
  int last_len = 0;
  logic bad = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_dat = '0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  int rsp_first = 0;
  int rdy_rise = 0;
  logic rv_prev = 1'b0;
  logic cr_prev = 1'b0;

  neuromorphic_x1_wb_master #(
    .TIMEOUT_CYCLES(TO),
    .IDLE_GAP(GAP),
    .ERR_CNT_W(ECW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (rdat),
    .wbm_ack_i (ack),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_no++;

  // slave acks combinationally in stb cycle number ack_at (0 = never)
  always @(posedge clk) stb_n <= wbm_stb_o ? stb_n + 1 : 0;
  assign ack = spur |
    (wbm_stb_o && ack_at != 0 && stb_n == ack_at - 1);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (wbm_stb_o) begin
      run++;
      if (wbm_adr_o !== exp_adr || wbm_dat_o !== exp_dat ||
          wbm_we_o !== exp_we || wbm_sel_o !== 4'hF ||
          wbm_cyc_o !== 1'b1)
        bad = 1'b1;
    end else if (run != 0) begin
      last_len = run;
      run = 0;
    end
    if (rsp_valid && !rv_prev) rsp_first = cyc_no;
    rv_prev = rsp_valid;
    if (cmd_ready && !cr_prev) rdy_rise = cyc_no;
    cr_prev = cmd_ready;
    if (rsp_valid && rsp_ready) begin
      hs_cyc = cyc_no + 1;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_we", 32'(rsp_we), 32'(e.we));
        chk("rsp_dat", rsp_dat, e.dat);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic push(input logic we, input logic [31:0] dat,
                      input logic err);
    rsp_t e;
    e.we = we;
    e.dat = dat;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic we, input logic [31:0] adr,
                      input logic [31:0] dat);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    cmd_we = we;
    cmd_adr = adr;
    cmd_dat = dat;
    cmd_valid = 1'b1;
    exp_we = we;
    exp_adr = adr;
    exp_dat = dat;
    bad = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    acc_cyc = cyc_no;
    chk("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("rsp_wait", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        s_we, s_err, bp_bad;
    logic [31:0] s_dat;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'hF);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // write, ack in 3rd stb cycle
    ack_at = 3;
    push(1'b1, 32'h0, 1'b0);
    send(1'b1, 32'h3000_0010, 32'hA5A5_5A5A);
    wait_rsp();
    chk("wr_stb_len", last_len, 32'd3);
    chk("wr_stable", 32'(bad), 32'd0);

    // read, ack in 1st stb cycle
    ack_at = 1;
    rdat = 32'h1234_5678;
    push(1'b0, 32'h1234_5678, 1'b0);
    send(1'b0, 32'h3000_0004, 32'h0);
    wait_rsp();
    chk("rd_lat_edges", rsp_first - acc_cyc + 1, 32'd2);
    chk("rd_stb_len", last_len, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rd_gap", rdy_rise - hs_cyc, GAP);

    // timeout
    ack_at = 0;
    push(1'b0, 32'h0, 1'b1);
    send(1'b0, 32'h3000_0008, 32'h0);
    wait_rsp();
    chk("to_stb_len", last_len, TO);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);

    // ack on the terminal timeout cycle
    ack_at = TO;
    rdat = 32'hCAFE_0001;
    push(1'b0, 32'hCAFE_0001, 1'b0);
    send(1'b0, 32'h3000_000C, 32'h0);
    wait_rsp();
    chk("term_stb_len", last_len, TO);
    chk("term_err_cnt", 32'(err_cnt), 32'd1);

    // backpressure with spurious ack in RESP
    ack_at = 2;
    rsp_ready = 1'b0;
    push(1'b1, 32'h0, 1'b0);
    send(1'b1, 32'h3000_0020, 32'h0BAD_F00D);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    s_we = rsp_we;
    s_err = rsp_err;
    s_dat = rsp_dat;
    @(posedge clk);
    #1;
    cmd_we = 1'b0;
    cmd_adr = 32'h3000_0024;
    cmd_dat = 32'h0;
    cmd_valid = 1'b1;
    spur = 1'b1;
    bp_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_we !== s_we ||
          rsp_err !== s_err || rsp_dat !== s_dat ||
          wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b0)
        bp_bad = 1'b1;
      @(posedge clk);
      #1;
      spur = 1'b0;
    end
    chk("bp_hold", 32'(bp_bad), 32'd0);
    ack_at = 1;
    rdat = 32'h0000_BEEF;
    push(1'b0, 32'h0000_BEEF, 1'b0);
    rsp_ready = 1'b1;
    send(1'b0, 32'h3000_0024, 32'h0);
    chk("bp_accept_edge", acc_cyc - hs_cyc, GAP + 1);
    wait_rsp();

    // error counter saturation
    ack_at = 0;
    for (int i = 0; i < 300; i++) begin
      push(1'b0, 32'h0, 1'b1);
      send(1'b0, 32'h3000_1000 + 32'(i * 4), 32'h0);
      wait_rsp();
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);

    // reset during the 2nd stb cycle
    push(1'b0, 32'h0, 1'b1);
    send(1'b0, 32'h3000_0030, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("mrst_stb", 32'(wbm_stb_o), 32'd0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    ack_at = 2;
    push(1'b1, 32'h0, 1'b0);
    send(1'b1, 32'h3000_0040, 32'h5555_AAAA);
    wait_rsp();
    chk("post_stb_len", last_len, 32'd2);
    chk("post_stable", 32'(bad), 32'd0);
    chk("post_err_cnt", 32'(err_cnt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
